// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the pipeline MEM stage.
package mem_stage_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned RD_W       = 3;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned PERF_W     = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Saturating increment for the performance counters.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/data_mem_sram.sv
// Data memory: synchronous write, combinational read, no reset; address wraps modulo DEPTH.
module data_mem_sram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;

   assign idx = IDX_W'(32'(addr) % DEPTH);

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: multi-cycle data-memory access with upstream stall and MEM/WB register.
// Optional perf counters are built when MEM_STAGE_PERF_CNT_EN is defined.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [RD_W-1:0]   ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_write_data,
   output logic [RD_W-1:0]   wb_rd,
   output logic              wb_reg_write
`ifdef MEM_STAGE_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_loads,
   output logic [PERF_W-1:0] perf_stores,
   output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

   localparam bit          MULTI    = (MEM_LAT >= 2);
   localparam int unsigned CNT_INIT = MULTI ? MEM_LAT - 2 : 0;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              mem_op, is_store, is_load, complete, mem_we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rdata;

   assign addr = ex_alu_result[ADDR_W-1:0];

   // Next-state, stall and completion decode; write wins when read and write are both set.
   always_comb begin
      mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
      is_store   = ex_valid & ex_mem_write;
      is_load    = ex_valid & ex_mem_read & ~ex_mem_write;
      state_next = state;
      cnt_next   = cnt;
      mem_stall  = 1'b0;
      complete   = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_op && MULTI) begin
               mem_stall  = 1'b1;
               state_next = BUSY;
               cnt_next   = CNT_W'(CNT_INIT);
            end else begin
               complete = 1'b1;
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               mem_stall = 1'b1;
               cnt_next  = cnt - CNT_W'(1);
            end else begin
               complete   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // A reset landing on the final cycle abandons the store.
      mem_we = complete & is_store & reset;
   end

   data_mem_sram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_sram (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr),
      .wdata (ex_store_data),
      .rdata (rdata)
   );

   // State, counter and MEM/WB register; non-completing cycles load a bubble.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         wb_valid      <= 1'b0;
         wb_write_data <= '0;
         wb_rd         <= '0;
         wb_reg_write  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (complete) begin
            wb_valid      <= ex_valid;
            wb_rd         <= ex_rd;
            wb_reg_write  <= ex_valid & ex_reg_write & (ex_rd != '0) & ~ex_mem_write;
            wb_write_data <= is_load ? rdata : ex_alu_result;
         end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
         end
      end
   end

`ifdef MEM_STAGE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_loads        <= '0;
         perf_stores       <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (complete && is_load) begin
            perf_loads <= sat_inc(perf_loads);
         end
         if (complete && is_store) begin
            perf_stores <= sat_inc(perf_stores);
         end
         if (mem_stall) begin
            perf_stall_cycles <= sat_inc(perf_stall_cycles);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: unit 0 (MEM_LAT=2, DEPTH=256) and unit 1 (MEM_LAT=4, DEPTH=16).
module tb_mem_stage;

   localparam int N = 2;

   typedef struct {
      int         cyc;
      logic [2:0] rd;
      logic       rw;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset         [N];
   logic       ex_valid      [N];
   logic [7:0] ex_alu_result [N];
   logic [7:0] ex_store_data [N];
   logic [2:0] ex_rd         [N];
   logic       ex_mem_read   [N];
   logic       ex_mem_write  [N];
   logic       ex_reg_write  [N];
   logic       mem_stall     [N];
   logic       wb_valid      [N];
   logic [7:0] wb_write_data [N];
   logic [2:0] wb_rd         [N];
   logic       wb_reg_write  [N];
`ifdef MEM_STAGE_PERF_CNT_EN
   logic [15:0] perf_loads        [N];
   logic [15:0] perf_stores       [N];
   logic [15:0] perf_stall_cycles [N];
`endif

   int         vecs = 0;
   int         errs = 0;
   int         cyc  = 0;
   bit         mon_en = 1'b0;
   logic [7:0] mdl [N][256];
   int         m_loads [N];
   int         m_stores[N];
   int         m_stalls[N];
   exp_t       q0[$];
   exp_t       q1[$];
   exp_t       me;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_stage #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .MEM_LAT(2)) u_dut0 (
      .clk(clk), .reset(reset[0]), .ex_valid(ex_valid[0]),
      .ex_alu_result(ex_alu_result[0]), .ex_store_data(ex_store_data[0]),
      .ex_rd(ex_rd[0]), .ex_mem_read(ex_mem_read[0]), .ex_mem_write(ex_mem_write[0]),
      .ex_reg_write(ex_reg_write[0]), .mem_stall(mem_stall[0]), .wb_valid(wb_valid[0]),
      .wb_write_data(wb_write_data[0]), .wb_rd(wb_rd[0]), .wb_reg_write(wb_reg_write[0])
`ifdef MEM_STAGE_PERF_CNT_EN
      , .perf_loads(perf_loads[0]), .perf_stores(perf_stores[0]),
      .perf_stall_cycles(perf_stall_cycles[0])
`endif
   );

   mem_stage #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .MEM_LAT(4)) u_dut1 (
      .clk(clk), .reset(reset[1]), .ex_valid(ex_valid[1]),
      .ex_alu_result(ex_alu_result[1]), .ex_store_data(ex_store_data[1]),
      .ex_rd(ex_rd[1]), .ex_mem_read(ex_mem_read[1]), .ex_mem_write(ex_mem_write[1]),
      .ex_reg_write(ex_reg_write[1]), .mem_stall(mem_stall[1]), .wb_valid(wb_valid[1]),
      .wb_write_data(wb_write_data[1]), .wb_rd(wb_rd[1]), .wb_reg_write(wb_reg_write[1])
`ifdef MEM_STAGE_PERF_CNT_EN
      , .perf_loads(perf_loads[1]), .perf_stores(perf_stores[1]),
      .perf_stall_cycles(perf_stall_cycles[1])
`endif
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic int dep_of(input int i);
      return (i == 0) ? 256 : 16;
   endfunction

   function automatic void chk(input string name, input int i, input logic [31:0] act,
                               input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s unit%0d: got %0h expected %0h (cycle %0d)", name, i, act, exp, cyc);
      end
   endfunction

   function automatic void qpush(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qpop(input int i);
      return (i == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   // Monitor: every WB result is matched in order against the scoreboard, including its cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < N; i++) begin
            if (wb_valid[i] === 1'b1) begin
               if (qsize(i) == 0) begin
                  chk("unexpected_wb", i, 32'(wb_valid[i]), 32'd0);
               end else begin
                  me = qpop(i);
                  chk("wb_cycle", i, 32'(cyc), 32'(me.cyc));
                  chk("wb_rd", i, 32'(wb_rd[i]), 32'(me.rd));
                  chk("wb_reg_write", i, 32'(wb_reg_write[i]), 32'(me.rw));
                  chk("wb_write_data", i, 32'(wb_write_data[i]), 32'(me.data));
               end
            end else begin
               chk("bubble_reg_write", i, 32'(wb_reg_write[i]), 32'd0);
            end
         end
      end
   end

   // Issue one instruction, hold it while stalled, and record what WB must show.
   task automatic do_op(input int i, input bit v, input bit rd_en, input bit wr_en, input bit rw,
                        input logic [7:0] alu, input logic [7:0] sd, input logic [2:0] rd);
      exp_t e;
      int   n, stalls, lat, a;
      bit   mop, ld, st;
      logic s;
      lat = lat_of(i);
      @(posedge clk); #1;
      ex_valid[i]      = v;
      ex_mem_read[i]   = rd_en;
      ex_mem_write[i]  = wr_en;
      ex_reg_write[i]  = rw;
      ex_alu_result[i] = alu;
      ex_store_data[i] = sd;
      ex_rd[i]         = rd;
      n   = cyc;
      mop = v && (rd_en || wr_en);
      st  = v && wr_en;
      ld  = v && rd_en && !wr_en;
      a   = int'(alu) % dep_of(i);
      if (v) begin
         e.cyc  = n + (mop ? lat : 1);
         e.rd   = rd;
         e.rw   = rw && (rd != 3'd0) && !wr_en;
         e.data = ld ? mdl[i][a] : alu;
         qpush(i, e);
      end
      if (st) mdl[i][a] = sd;
      if (ld) m_loads[i]++;
      if (st) m_stores[i]++;
      if (mop) m_stalls[i] += lat - 1;
      stalls = 0;
      do begin
         @(negedge clk);
         s = mem_stall[i];
         if (s === 1'b1) stalls++;
      end while (s === 1'b1 && stalls < 20);
      chk("stall_cycles", i, 32'(stalls), 32'(mop ? lat - 1 : 0));
   endtask

   task automatic go_idle(input int i);
      @(posedge clk); #1;
      ex_valid[i] = 1'b0;
   endtask

   // Store abandoned by a reset while the access is still in flight.
   task automatic reset_abort(input int i, input logic [7:0] alu, input logic [7:0] sd);
      @(posedge clk); #1;
      ex_valid[i]      = 1'b1;
      ex_mem_read[i]   = 1'b0;
      ex_mem_write[i]  = 1'b1;
      ex_reg_write[i]  = 1'b0;
      ex_alu_result[i] = alu;
      ex_store_data[i] = sd;
      ex_rd[i]         = 3'd0;
      @(posedge clk); #1;
      reset[i] = 1'b0;
      @(posedge clk); #1;
      reset[i]    = 1'b1;
      ex_valid[i] = 1'b0;
      m_loads[i]  = 0;
      m_stores[i] = 0;
      m_stalls[i] = 0;
      @(negedge clk);
      chk("abort_stall", i, 32'(mem_stall[i]), 32'd0);
      chk("abort_wb_valid", i, 32'(wb_valid[i]), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         reset[i] = 1'b0; ex_valid[i] = 1'b0; ex_mem_read[i] = 1'b0; ex_mem_write[i] = 1'b0;
         ex_reg_write[i] = 1'b0; ex_alu_result[i] = 8'h00; ex_store_data[i] = 8'h00;
         ex_rd[i] = 3'd0; m_loads[i] = 0; m_stores[i] = 0; m_stalls[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) reset[i] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk("rst_wb_valid", i, 32'(wb_valid[i]), 32'd0);
         chk("rst_wb_data", i, 32'(wb_write_data[i]), 32'd0);
         chk("rst_wb_rd", i, 32'(wb_rd[i]), 32'd0);
         chk("rst_wb_reg_write", i, 32'(wb_reg_write[i]), 32'd0);
         chk("rst_stall", i, 32'(mem_stall[i]), 32'd0);
      end
      mon_en = 1'b1;

      // Give every memory word a known value.
      for (int i = 0; i < N; i++) begin
         for (int a = 0; a < dep_of(i); a++)
            do_op(i, 1'b1, 1'b0, 1'b1, 1'b0, 8'(a), 8'($urandom), 3'd0);
         go_idle(i);
      end

      // Unit 0: ALU op, store/load, rd=0, read+write, reset abort.
      do_op(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFB, 8'h00, 3'd3);
      do_op(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h5A, 3'd1);
      do_op(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2);
      do_op(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd0);
      do_op(0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 8'hC3, 3'd4);
      do_op(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 3'd1);
      do_op(0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 3'd1);
      reset_abort(0, 8'h20, 8'hEE);
      do_op(0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 3'd6);
      for (int k = 0; k < 150; k++)
         do_op(0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom));
      go_idle(0);

      // Unit 1: address wrap, long-latency load, random traffic.
      reset_abort(1, 8'h05, 8'h99);
      do_op(1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 8'h00, 3'd2);
      do_op(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h13, 8'h77, 3'd0);
      do_op(1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 3'd5);
      do_op(1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 3'd7);
      for (int k = 0; k < 100; k++)
         do_op(1, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom));
      go_idle(1);

      repeat (6) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk("pending_wb", i, 32'(qsize(i)), 32'd0);
`ifdef MEM_STAGE_PERF_CNT_EN
         chk("perf_loads", i, 32'(perf_loads[i]), 32'(m_loads[i]));
         chk("perf_stores", i, 32'(perf_stores[i]), 32'(m_stores[i]));
         chk("perf_stall_cycles", i, 32'(perf_stall_cycles[i]), 32'(m_stalls[i]));
`endif
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
